// File: rtl/serializer_arbiter.sv
// ---------------------------------------------------------------------------
// serializer_arbiter
//
// Round-robin scheduler sharing one parallel-to-serial serializer among four
// byte-stream lanes. Time is divided into 8-cycle byte slots; at the last
// edge of each slot (the decision edge) one requesting lane is picked and its
// byte is presented on DATA_OUT for the whole next slot.
//
// Optional feature macro: ARB_SKIP_EN
//   When defined, every SKP_PERIOD-th slot is a skip slot carrying SKP_SYM
//   with Valid=1; no lane is granted in that slot.
//
// Parameters
//   IDLE_SYM    byte driven when no lane is granted
//   SKP_SYM     byte driven in skip slots (ARB_SKIP_EN only)
//   SKP_PERIOD  slots per skip interval, 2..16 (ARB_SKIP_EN only)
//
// Ports
//   CLK       in   bit clock
//   RESET     in   synchronous active-low reset
//   REQ       in   per-lane request, held until the lane sees its GNT
//   DATA_REQ  in   lane k byte in bits [8k+7:8k]
//   GNT       out  one-hot, one-cycle pulse: lane byte taken
//   DATA_OUT  out  byte to the serializer, constant for a whole slot
//   Valid     out  slot carries a lane byte (or skip symbol)
//   LOAD      out  one-cycle strobe on the first cycle of every slot
// ---------------------------------------------------------------------------
module serializer_arbiter #(
    parameter logic [7:0]  IDLE_SYM   = 8'hBC,
    parameter logic [7:0]  SKP_SYM    = 8'h1C,
    parameter int unsigned SKP_PERIOD = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  REQ,
    input  logic [31:0] DATA_REQ,
    output logic [3:0]  GNT,
    output logic [7:0]  DATA_OUT,
    output logic        Valid,
    output logic        LOAD
);

    logic [2:0] slot_cnt_q, slot_cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [3:0] gnt_q, gnt_d;
    logic       load_q, load_d;

    logic       found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       skip_slot;

`ifdef ARB_SKIP_EN
    localparam logic [3:0] SKP_LAST = 4'(SKP_PERIOD - 1);

    logic [3:0] skp_cnt_q, skp_cnt_d;

    assign skip_slot = (skp_cnt_q == SKP_LAST);
`else
    // Skip parameters have no effect in this build.
    logic unused_skip_cfg;
    assign unused_skip_cfg = ^{SKP_SYM, SKP_PERIOD[4:0]};
    assign skip_slot       = 1'b0;
`endif

    // Search starts one past the last winner; i==4 wraps back onto ptr
    // itself so a lone requester can be granted back-to-back.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && REQ[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        slot_cnt_d = slot_cnt_q + 3'd1;
        ptr_d      = ptr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        gnt_d      = 4'b0000;
        load_d     = 1'b0;
`ifdef ARB_SKIP_EN
        skp_cnt_d  = skp_cnt_q;
`endif
        if (slot_cnt_q == 3'd7) begin
            load_d = 1'b1;
`ifdef ARB_SKIP_EN
            skp_cnt_d = skip_slot ? 4'd0 : skp_cnt_q + 4'd1;
`endif
            if (skip_slot) begin
                // REQ is ignored here; pending lanes keep their place.
                data_d  = SKP_SYM;
                valid_d = 1'b1;
            end else if (found) begin
                ptr_d   = win_idx;
                data_d  = DATA_REQ[{win_idx, 3'b000} +: 8];
                valid_d = 1'b1;
                gnt_d   = 4'b0001 << win_idx;
            end else begin
                data_d  = IDLE_SYM;
                valid_d = 1'b0;
            end
        end
    end

    // ptr resets to 3 so lane 0 is searched first.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            slot_cnt_q <= 3'd0;
            ptr_q      <= 2'd3;
            data_q     <= IDLE_SYM;
            valid_q    <= 1'b0;
            gnt_q      <= 4'b0000;
            load_q     <= 1'b0;
`ifdef ARB_SKIP_EN
            skp_cnt_q  <= 4'd0;
`endif
        end else begin
            slot_cnt_q <= slot_cnt_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            gnt_q      <= gnt_d;
            load_q     <= load_d;
`ifdef ARB_SKIP_EN
            skp_cnt_q  <= skp_cnt_d;
`endif
        end
    end

    assign GNT      = gnt_q;
    assign DATA_OUT = data_q;
    assign Valid    = valid_q;
    assign LOAD     = load_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serializer_arbiter
//
// Scoreboard bench for serializer_arbiter. Each slot the stimulus thread sets
// REQ just before the decision edge and pushes the expected slot contents;
// the monitor pops an entry on every expected LOAD and checks DATA_OUT/Valid
// for the whole slot, plus GNT/LOAD every cycle.
// ---------------------------------------------------------------------------
module tb_serializer_arbiter;

    logic        CLK;
    logic        RESET;
    logic [3:0]  REQ;
    logic [31:0] DATA_REQ;
    logic [3:0]  GNT;
    logic [7:0]  DATA_OUT;
    logic        Valid;
    logic        LOAD;

    serializer_arbiter #(
        .IDLE_SYM   (8'hBC),
        .SKP_SYM    (8'h1C),
        .SKP_PERIOD (4)
    ) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ),
        .DATA_REQ (DATA_REQ),
        .GNT      (GNT),
        .DATA_OUT (DATA_OUT),
        .Valid    (Valid),
        .LOAD     (LOAD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slot timing reference: decision edge is the 8th edge after reset.
    logic [2:0] tb_phase  = 3'd0;
    logic       tb_dec    = 1'b0;
    logic       rst_seen  = 1'b0;
    logic [7:0] cur_data  = 8'hBC;
    logic       cur_valid = 1'b0;

    always @(posedge CLK) begin
        rst_seen <= !RESET;
        if (!RESET) begin
            tb_phase <= 3'd0;
            tb_dec   <= 1'b0;
        end else begin
            tb_dec   <= (tb_phase == 3'd7);
            tb_phase <= tb_phase + 3'd1;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (rst_seen) begin
            cur_data  = 8'hBC;
            cur_valid = 1'b0;
            chk("rst_data",  32'(DATA_OUT), 32'h0BC);
            chk("rst_valid", 32'(Valid), 32'd0);
            chk("rst_gnt",   32'(GNT), 32'd0);
            chk("rst_load",  32'(LOAD), 32'd0);
        end else begin
            chk("load", 32'(LOAD), 32'(tb_dec));
            if (tb_dec) begin
                chk("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e         = sb.pop_front();
                    cur_data  = e.data;
                    cur_valid = e.valid;
                    chk("gnt", 32'(GNT), 32'(e.gnt));
                end
            end else begin
                chk("gnt_quiet", 32'(GNT), 32'd0);
            end
            chk("data",  32'(DATA_OUT), 32'(cur_data));
            chk("valid", 32'(Valid), 32'(cur_valid));
        end
    end

    // lane >= 0: grant to that lane; -1: idle slot; -2: skip slot.
    task automatic push_exp(input int lane);
        exp_t e;
        if (lane >= 0) begin
            e.gnt   = 4'b0001 << lane;
            e.data  = DATA_REQ[8*lane +: 8];
            e.valid = 1'b1;
        end else if (lane == -2) begin
            e.gnt   = 4'b0000;
            e.data  = 8'h1C;
            e.valid = 1'b1;
        end else begin
            e.gnt   = 4'b0000;
            e.data  = 8'hBC;
            e.valid = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called on the negedge just before a decision edge. REQ switches to
    // req_mid one cycle after the decision edge; returns before the next one.
    task automatic slot(input logic [3:0] req_dec, input logic [3:0] req_mid, input int lane);
        REQ = req_dec;
        push_exp(lane);
        @(negedge CLK);
        REQ = req_mid;
        repeat (7) @(negedge CLK);
    endtask

    initial begin
        RESET    = 1'b0;
        REQ      = 4'b0000;
        DATA_REQ = 32'h0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (7) @(negedge CLK);

`ifdef ARB_SKIP_EN
        DATA_REQ = 32'h0000_0077;
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0001, -2);
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0000, -2);
        slot(4'b0000, 4'b0000, -1);
`else
        // First slot after reset: idle.
        slot(4'b0000, 4'b0000, -1);

        // All lanes requesting: strict rotation from lane 0.
        DATA_REQ = 32'h4332_2110;
        slot(4'b1111, 4'b1111, 0);
        slot(4'b1111, 4'b1111, 1);
        slot(4'b1111, 4'b1111, 2);
        slot(4'b1111, 4'b1111, 3);
        slot(4'b1111, 4'b0000, 0);

        // Single lane, dropped after its grant.
        DATA_REQ = 32'h00A5_0000;
        slot(4'b0100, 4'b0000, 2);
        slot(4'b0000, 4'b0000, -1);

        // Late request waits a slot; withdrawn request is never granted.
        DATA_REQ = 32'h4433_2211;
        slot(4'b0000, 4'b0010, -1);
        slot(4'b0010, 4'b0000, 1);
        slot(4'b0000, 4'b1000, -1);
        slot(4'b0000, 4'b0000, -1);

        // Lone lane streams; another requester cuts in once.
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0001, 4'b0001, 0);
        slot(4'b0101, 4'b0001, 2);
        slot(4'b0001, 4'b0000, 0);

        // Pointer wrap between lanes 3 and 0.
        slot(4'b1001, 4'b1001, 3);
        slot(4'b1001, 4'b0000, 0);

        // Reset in the middle of a granted slot.
        DATA_REQ = 32'h0000_005A;
        REQ = 4'b0001;
        push_exp(0);
        @(negedge CLK);
        repeat (4) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        REQ   = 4'b0000;
        repeat (7) @(negedge CLK);
        DATA_REQ = 32'h9988_7766;
        slot(4'b1011, 4'b0000, 0);
        slot(4'b0000, 4'b0000, -1);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
